pcie_scrambler_pipe: RTL and testbench
======================================

Name: pcie_scrambler_pipe

Overview:
Parametrised, pipelined Gen3+ PCIe transmit scrambler. It sits between the MAC/DLL block stream and the 128b/130b encoder.
- Scrambles data blocks DW bits per cycle, in SCR_W-bit chunks, one chunk per pipeline stage.
- Bypasses control blocks.
- Supports LFSR reseed (EIEOS), runtime scramble disable and full valid/ready backpressure.

Parameters:
DW, 128, block data width; must be a multiple of SCR_W.
SCR_W, 32, bits scrambled per pipeline stage; STAGES = DW/SCR_W.
LFSR_W, 23, LFSR width; fixed at 23 for Gen3 (elaboration error otherwise).
POLY, 23'h210125, Galois tap mask for x^23+x^21+x^16+x^8+x^5+x^2+1.
SEED, 23'h1DBFBC, reseed/reset value (lane-0 seed).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
scrambler_enable  in  1  0 = data blocks pass unscrambled and the LFSR holds
in_data  in  DW  unscrambled payload; bit 0 is first on the wire
in_is_ctl  in  1  1 = control block: bypass, LFSR does not advance
in_lfsr_rst  in  1  reseed LFSR to SEED after this block (EIEOS)
in_valid  in  1  input block valid
in_ready  out  1  block accepted when in_valid && in_ready
out_data  out  DW  scrambled or bypassed payload
out_is_ctl  out  1  in_is_ctl delayed with its block
out_valid  out  1  output block valid
out_ready  in  1  downstream accept

Behaviour:
- Reset: out_data=0, out_is_ctl=0, out_valid=0, all stage valids=0, master LFSR=SEED. in_ready=1 one cycle after reset deassert.
- Bit-serial reference model. For each data bit i = 0..DW-1: out[i] = in[i] ^ s[22]; then s = {s[21:0],1'b0} ^ (s[22] ? POLY : 0).
- Master LFSR: on acceptance of a data block (in_is_ctl=0) with scrambler_enable=1, the master state advances DW steps in one cycle (unrolled XOR matrix).
- The pre-advance state is captured into stage 0 alongside the block.
- Stage k (k = 0..STAGES-1):
  - holds {data, is_ctl, en, state};
  - scrambles chunk bits [k*SCR_W +: SCR_W] with the carried state;
  - advances the carried state SCR_W steps;
  - passes everything to stage k+1.
- Latency: exactly STAGES cycles from acceptance to out_valid when out_ready is held high. Throughput: 1 block/cycle.
- Bypass: if is_ctl=1 or en=0 (en = scrambler_enable sampled at acceptance), data passes unmodified and the master LFSR does not advance.
- Reseed: an accepted block with in_lfsr_rst=1 is first processed with the current state. The master then loads SEED, overriding the DW advance in the same cycle.
- in_lfsr_rst is honoured on control and data blocks alike, and regardless of scrambler_enable.
- Backpressure: pipe_adv = !out_valid || out_ready. All stages shift only when pipe_adv=1; in_ready = pipe_adv.
  - No bubble collapse.
  - A stalled pipeline holds every stage's contents and the master LFSR unchanged.
- Empty stages: valid=0 slots propagate as bubbles. The master LFSR never advances without an accepted data block.
- scrambler_enable changes mid-stream affect only blocks accepted after the change. Blocks already in flight keep their sampled en.
- Async reset mid-operation flushes all in-flight blocks (out_valid=0) and loads SEED.

Optional Feature:
Macro SCR_SEED_PORT_EN.
- Defined: adds input port cfg_seed [LFSR_W-1:0]. The reset value and every reseed load cfg_seed, sampled at the reseed cycle; a reset loads cfg_seed as sampled at reset deassertion. The SEED parameter is unused.
- Undefined: no cfg_seed port; SEED is used for reset and reseed.

Test Plan:
- Reset, then 3 control blocks in_data=128'hA5A5…A5, in_is_ctl=1 -> out_data identical after STAGES=4 cycles; master LFSR stays 23'h1DBFBC.
- Reset, 1 data block in_data=0 -> out_data equals the first 128 keystream bits of the reference model from SEED; master LFSR equals SEED advanced 128 steps.
- 4 back-to-back data blocks of random data, out_ready=1 -> out_valid on 4 consecutive cycles starting cycle 4; each block matches the continuous bit-serial model over 512 bits.
- Stream with out_ready=0 for 5 cycles mid-burst -> in_ready=0, out_data/out_valid held stable, no blocks lost or duplicated; results match the model.
- Data block with in_lfsr_rst=1, then data block in_data=0 -> second output equals the first 128 keystream bits from SEED, same as the second test.
- scrambler_enable=0 for 2 data blocks, then 1 -> first two pass unscrambled; third scrambled from the unchanged prior LFSR state.

Source files
------------

// File: rtl/pcie_scrambler_pipe.sv
// Pipelined Gen3+ PCIe transmit scrambler: DW-bit blocks, SCR_W bits scrambled per stage.
// Optional macro SCR_SEED_PORT_EN adds a cfg_seed input that replaces SEED for reset and reseed.
module pcie_scrambler_pipe #(
    parameter int                DW     = 128,
    parameter int                SCR_W  = 32,
    parameter int                LFSR_W = 23,
    parameter logic [LFSR_W-1:0] POLY   = 23'h210125,
    parameter logic [LFSR_W-1:0] SEED   = 23'h1DBFBC
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef SCR_SEED_PORT_EN
    input  logic [LFSR_W-1:0] cfg_seed,
`endif
    input  logic              scrambler_enable,
    input  logic [DW-1:0]     in_data,
    input  logic              in_is_ctl,
    input  logic              in_lfsr_rst,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DW-1:0]     out_data,
    output logic              out_is_ctl,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int STAGES = DW / SCR_W;

    generate
        if (LFSR_W != 23) begin : g_bad_lfsr_w
            $error("pcie_scrambler_pipe: LFSR_W must be 23 for Gen3 scrambling");
        end
        if ((DW % SCR_W) != 0) begin : g_bad_dw
            $error("pcie_scrambler_pipe: DW must be a multiple of SCR_W");
        end
    endgenerate

    // One Galois step: shift toward the MSB and fold the taps back in when the MSB falls out.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        lfsr_step = {s[LFSR_W-2:0], 1'b0} ^ (s[LFSR_W-1] ? POLY : {LFSR_W{1'b0}});
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_adv_dw(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] t;
        t = s;
        for (int i = 0; i < DW; i++) t = lfsr_step(t);
        return t;
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_adv_chunk(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] t;
        t = s;
        for (int i = 0; i < SCR_W; i++) t = lfsr_step(t);
        return t;
    endfunction

    function automatic logic [SCR_W-1:0] keystream_chunk(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] t;
        logic [SCR_W-1:0]  k;
        t = s;
        k = {SCR_W{1'b0}};
        for (int i = 0; i < SCR_W; i++) begin
            k[i] = t[LFSR_W-1];
            t    = lfsr_step(t);
        end
        return k;
    endfunction

`ifdef SCR_SEED_PORT_EN
    localparam logic [LFSR_W-1:0] RST_STATE = {LFSR_W{1'b0}};
    logic [LFSR_W-1:0] seed_s;
    assign seed_s = cfg_seed;
`else
    localparam logic [LFSR_W-1:0] RST_STATE = SEED;
    logic [LFSR_W-1:0] seed_s;
    assign seed_s = SEED;
`endif

    logic [LFSR_W-1:0] master_r;
    logic              init_done_r;
    logic              pipe_adv_s;
    logic              accept_s;

    logic [DW-1:0]     stg_data_r  [STAGES];
    logic [LFSR_W-1:0] stg_state_r [STAGES];
    logic [STAGES-1:0] stg_ctl_r;
    logic [STAGES-1:0] stg_en_r;
    logic [STAGES-1:0] stg_valid_r;
    logic [DW-1:0]     nxt_data_s  [STAGES];

    // Nothing is accepted until the first cycle after reset, when the seed has been loaded.
    assign pipe_adv_s = init_done_r && (!out_valid || out_ready);
    assign in_ready   = pipe_adv_s;
    assign accept_s   = in_valid && pipe_adv_s;

    // Master LFSR: reseed wins over the block advance; bypassed blocks leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            master_r    <= RST_STATE;
            init_done_r <= 1'b0;
        end else if (!init_done_r) begin
            master_r    <= seed_s;
            init_done_r <= 1'b1;
        end else if (accept_s) begin
            if (in_lfsr_rst) begin
                master_r <= seed_s;
            end else if (!in_is_ctl && scrambler_enable) begin
                master_r <= lfsr_adv_dw(master_r);
            end else begin
                master_r <= master_r;
            end
        end
    end

    // Each stage scrambles only its own chunk with the state it carries.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt_data_s[k] = stg_data_r[k];
            if (!stg_ctl_r[k] && stg_en_r[k]) begin
                nxt_data_s[k][k*SCR_W +: SCR_W] =
                    stg_data_r[k][k*SCR_W +: SCR_W] ^ keystream_chunk(stg_state_r[k]);
            end else begin
                nxt_data_s[k] = stg_data_r[k];
            end
        end
    end

    // Pipeline shift: every stage and the output register move together or not at all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                stg_data_r[k]  <= {DW{1'b0}};
                stg_state_r[k] <= {LFSR_W{1'b0}};
            end
            stg_ctl_r   <= {STAGES{1'b0}};
            stg_en_r    <= {STAGES{1'b0}};
            stg_valid_r <= {STAGES{1'b0}};
            out_data    <= {DW{1'b0}};
            out_is_ctl  <= 1'b0;
            out_valid   <= 1'b0;
        end else if (pipe_adv_s) begin
            stg_valid_r[0] <= in_valid;
            stg_data_r[0]  <= in_data;
            stg_ctl_r[0]   <= in_is_ctl;
            stg_en_r[0]    <= scrambler_enable;
            stg_state_r[0] <= master_r;
            for (int k = 1; k < STAGES; k++) begin
                stg_valid_r[k] <= stg_valid_r[k-1];
                stg_data_r[k]  <= nxt_data_s[k-1];
                stg_ctl_r[k]   <= stg_ctl_r[k-1];
                stg_en_r[k]    <= stg_en_r[k-1];
                stg_state_r[k] <= lfsr_adv_chunk(stg_state_r[k-1]);
            end
            out_valid  <= stg_valid_r[STAGES-1];
            out_data   <= nxt_data_s[STAGES-1];
            out_is_ctl <= stg_ctl_r[STAGES-1];
        end
    end

endmodule

// File: tb/tb_pcie_scrambler_pipe.sv
// Directed bench for pcie_scrambler_pipe; expected data comes from a bit-serial scrambler model.
module tb_pcie_scrambler_pipe;

    localparam int          DW     = 128;
    localparam int          STAGES = 4;
    localparam logic [22:0] POLY   = 23'h210125;
    localparam logic [22:0] SEED   = 23'h1DBFBC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          scrambler_enable = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_is_ctl = 1'b0;
    logic          in_lfsr_rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_is_ctl;
    logic          out_valid;
    logic          out_ready = 1'b1;

    pcie_scrambler_pipe dut (
        .clk(clk), .rst_n(rst_n),
`ifdef SCR_SEED_PORT_EN
        .cfg_seed(SEED),
`endif
        .scrambler_enable(scrambler_enable), .in_data(in_data), .in_is_ctl(in_is_ctl),
        .in_lfsr_rst(in_lfsr_rst), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_is_ctl(out_is_ctl), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [DW-1:0] d; logic c; int t; } obs_t;
    obs_t got_q[$];
    obs_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [22:0]   m_state;
    logic [DW-1:0] key0;
    localparam logic [DW-1:0] A5 = {16{8'hA5}};

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: a beat is recorded when it will be taken at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) got_q.push_back('{d: out_data, c: out_is_ctl, t: cyc});
    end

    // Bit-serial reference scrambler in acceptance order.
    task automatic model_apply(input logic [DW-1:0] d, input logic ctl, rst, en, output logic [DW-1:0] o);
        o = d;
        if (!ctl && en) begin
            for (int i = 0; i < DW; i++) begin
                o[i]    = d[i] ^ m_state[22];
                m_state = {m_state[21:0], 1'b0} ^ (m_state[22] ? POLY : 23'h0);
            end
        end
        if (rst) m_state = SEED;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_is_ctl = 1'b0; in_lfsr_rst = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        out_ready = 1'b1; scrambler_enable = 1'b1; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        m_state = SEED;
        got_q.delete(); exp_q.delete();
    endtask

    // Present one block and hold it until accepted; returns the acceptance cycle.
    task automatic drive(input logic [DW-1:0] d, input logic ctl, rst, en, output int acc);
        logic [DW-1:0] o;
        logic ok;
        in_data = d; in_is_ctl = ctl; in_lfsr_rst = rst; scrambler_enable = en; in_valid = 1'b1;
        ok = 1'b0; acc = -1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL accept_timeout got in_ready=0 want 1 within 50 cycles");
        end else begin
            acc = cyc;
            model_apply(d, ctl, rst, en, o);
            exp_q.push_back('{d: o, c: ctl, t: 0});
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && got_q.size() < exp_q.size(); i++) begin @(posedge clk); #1; end
        repeat (6) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL rst_out_data got %h want 0", out_data); end
        n_cmp++; if (out_is_ctl !== 1'b0) begin n_bad++; $display("FAIL rst_out_is_ctl got %b want 0", out_is_ctl); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_control();
        int acc0, acc;
        do_reset();
        drive(A5, 1'b1, 1'b0, 1'b1, acc0);
        drive(A5, 1'b1, 1'b0, 1'b1, acc);
        drive(A5, 1'b1, 1'b0, 1'b1, acc);
        drive('0, 1'b0, 1'b0, 1'b1, acc);
        idle(); drain();
        n_cmp++; if (got_q.size() !== 4) begin n_bad++; $display("FAIL ctl_count got %0d want 4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 3; i++) begin
            n_cmp++;
            if (got_q[i].d !== A5 || got_q[i].c !== 1'b1) begin
                n_bad++; $display("FAIL ctl_blk%0d got %h/%b want %h/1", i, got_q[i].d, got_q[i].c, A5);
            end
        end
        if (got_q.size() >= 4) begin
            n_cmp++; if (got_q[0].t !== acc0 + STAGES) begin n_bad++; $display("FAIL ctl_latency got %0d want %0d", got_q[0].t - acc0, STAGES); end
            n_cmp++; if (got_q[3].d !== key0) begin n_bad++; $display("FAIL ctl_lfsr_held got %h want %h", got_q[3].d, key0); end
        end
    endtask

    task automatic test_single_data();
        int acc;
        do_reset();
        drive('0, 1'b0, 1'b0, 1'b1, acc);
        idle(); drain();
        n_cmp++; if (got_q.size() !== 1) begin n_bad++; $display("FAIL single_count got %0d want 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            n_cmp++; if (got_q[0].d !== key0 || got_q[0].c !== 1'b0) begin n_bad++; $display("FAIL single_keystream got %h want %h", got_q[0].d, key0); end
            n_cmp++; if (got_q[0].t !== acc + STAGES) begin n_bad++; $display("FAIL single_latency got %0d want %0d", got_q[0].t - acc, STAGES); end
        end
    endtask

    task automatic test_back_to_back();
        int acc0, acc;
        do_reset();
        drive({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 1'b1, acc0);
        for (int i = 1; i < 4; i++) drive({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 1'b1, acc);
        n_cmp++; if (acc !== acc0 + 3) begin n_bad++; $display("FAIL b2b_input_rate got %0d want %0d", acc - acc0, 3); end
        idle(); drain();
        n_cmp++; if (got_q.size() !== 4) begin n_bad++; $display("FAIL b2b_count got %0d want 4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].d !== exp_q[i].d || got_q[i].t !== acc0 + STAGES + i) begin
                n_bad++; $display("FAIL b2b_blk%0d got %h @%0d want %h @%0d", i, got_q[i].d, got_q[i].t, exp_q[i].d, acc0 + STAGES + i);
            end
        end
    endtask

    task automatic test_stall();
        int acc;
        logic [DW-1:0] hold_d;
        do_reset();
        fork
            begin
                for (int i = 0; i < 8; i++) drive({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 1'b1, acc);
                idle();
            end
            begin
                for (int i = 0; i < 20 && !out_valid; i++) begin @(posedge clk); #1; end
                @(posedge clk); #1;
                out_ready = 1'b0; hold_d = out_data;
                repeat (5) begin
                    @(negedge clk);
                    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
                    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_out_valid got %b want 1", out_valid); end
                    n_cmp++; if (out_data !== hold_d) begin n_bad++; $display("FAIL stall_out_data got %h want %h", out_data, hold_d); end
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        n_cmp++; if (got_q.size() !== 8) begin n_bad++; $display("FAIL stall_count got %0d want 8", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].d !== exp_q[i].d) begin n_bad++; $display("FAIL stall_blk%0d got %h want %h", i, got_q[i].d, exp_q[i].d); end
        end
    endtask

    task automatic test_reseed();
        int acc;
        do_reset();
        drive({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, 1'b1, acc);
        drive('0, 1'b0, 1'b0, 1'b1, acc);
        drive({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 1'b1, acc);
        drive(A5, 1'b1, 1'b1, 1'b1, acc);
        drive('0, 1'b0, 1'b0, 1'b1, acc);
        idle(); drain();
        n_cmp++; if (got_q.size() !== 5) begin n_bad++; $display("FAIL reseed_count got %0d want 5", got_q.size()); end
        if (got_q.size() >= 5) begin
            n_cmp++; if (got_q[1].d !== key0) begin n_bad++; $display("FAIL reseed_data got %h want %h", got_q[1].d, key0); end
            n_cmp++; if (got_q[4].d !== key0) begin n_bad++; $display("FAIL reseed_ctl got %h want %h", got_q[4].d, key0); end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].d !== exp_q[i].d || got_q[i].c !== exp_q[i].c) begin
                n_bad++; $display("FAIL reseed_blk%0d got %h/%b want %h/%b", i, got_q[i].d, got_q[i].c, exp_q[i].d, exp_q[i].c);
            end
        end
    endtask

    task automatic test_enable();
        int acc;
        logic [DW-1:0] d [3];
        do_reset();
        for (int i = 0; i < 3; i++) d[i] = {$urandom, $urandom, $urandom, $urandom};
        drive(d[0], 1'b0, 1'b0, 1'b0, acc);
        drive(d[1], 1'b0, 1'b0, 1'b0, acc);
        drive(d[2], 1'b0, 1'b0, 1'b1, acc);
        idle(); drain();
        n_cmp++; if (got_q.size() !== 3) begin n_bad++; $display("FAIL en_count got %0d want 3", got_q.size()); end
        if (got_q.size() >= 3) begin
            n_cmp++; if (got_q[0].d !== d[0]) begin n_bad++; $display("FAIL en_off0 got %h want %h", got_q[0].d, d[0]); end
            n_cmp++; if (got_q[1].d !== d[1]) begin n_bad++; $display("FAIL en_off1 got %h want %h", got_q[1].d, d[1]); end
            n_cmp++; if (got_q[2].d !== (d[2] ^ key0)) begin n_bad++; $display("FAIL en_on got %h want %h", got_q[2].d, d[2] ^ key0); end
        end
    endtask

    task automatic test_async_reset();
        int acc;
        do_reset();
        drive({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 1'b1, acc);
        drive({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 1'b1, acc);
        idle();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_out_valid got %b want 0", out_valid); end
        got_q.delete(); exp_q.delete(); m_state = SEED;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive('0, 1'b0, 1'b0, 1'b1, acc);
        idle(); drain();
        n_cmp++; if (got_q.size() !== 1) begin n_bad++; $display("FAIL arst_count got %0d want 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            n_cmp++; if (got_q[0].d !== key0) begin n_bad++; $display("FAIL arst_seed got %h want %h", got_q[0].d, key0); end
        end
    endtask

    initial begin
        m_state = SEED;
        model_apply('0, 1'b0, 1'b0, 1'b1, key0);
        m_state = SEED;
        test_reset();
        test_control();
        test_single_data();
        test_back_to_back();
        test_stall();
        test_reseed();
        test_enable();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no finish want finish before 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
